store_checker: RTL and testbench
================================

Name: store_checker

Overview:
- Synthesizable, parametrised self-check monitor for the processor data-memory write port (mem_write / data_adr / write_data).
- Compares every store against an ordered table of expected (address, data) pairs and tolerates stores to one "scratch" address.
- Raises sticky pass/fail with a diagnostic code.
- Used in simulation benches and on the FPGA board, where outputs drive LEDs alongside the VGA top.

Parameters:
- N_EXP, 2, number of expected stores in the table (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- EXP_ADDR, {32'd96, 32'd100}, packed array [N_EXP] of expected addresses, index 0 first.
- EXP_DATA, {32'd0, 32'd7}, packed array [N_EXP] of expected data.
- IGNORE_EN, 1, enables the scratch-address exemption.
- IGNORE_ADDR, 96, scratch address whose stores are ignored when not expected.
- TIMEOUT, 1000, cycles after enable deassert-to-run before timeout fail; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  checking enabled; while low, state holds and the cycle counter does not advance.
- mem_write  in  1  store strobe from core.
- data_adr  in  ADDR_W  store address.
- write_data  in  DATA_W  store data.
- done  out  1  check finished (pass or fail), sticky.
- pass  out  1  all N_EXP stores matched in order, sticky.
- fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout.
- match_idx  out  $clog2(N_EXP+1)  number of expected stores matched so far.
- fail_addr  out  ADDR_W  address of the offending store (0 on timeout).
- fail_data  out  DATA_W  data of the offending store (0 on timeout).
- cycle_cnt  out  32  enabled cycles since reset, saturating at all-ones.

Behaviour:
- Reset: on any rising edge with reset==0, all outputs go to 0 and the FSM enters RUN. This is valid mid-run or after done, and overrides every other event.
- FSM states:
  - RUN → PASS when the store matching table index N_EXP-1 is accepted.
  - RUN → FAIL on mismatch, unexpected address, or timeout.
  - PASS and FAIL are absorbing until reset.
- All inputs are sampled on the rising clk edge with en==1 and state RUN. Outputs update that same edge (1-cycle latency from the sampled store to the registered result).
- Store evaluation, with k = match_idx, in priority order:
  1. data_adr==EXP_ADDR[k] and write_data==EXP_DATA[k]: match_idx←k+1; if k+1==N_EXP, then pass←1, done←1.
  2. data_adr==EXP_ADDR[k] with different data: FAIL, code 1.
  3. IGNORE_EN and data_adr==IGNORE_ADDR: no state change.
  4. Otherwise: FAIL, code 2.
  - fail_addr and fail_data capture the store inputs on codes 1 and 2.
- Rule 1 beats rule 3, so an expected store to IGNORE_ADDR consumes a table entry.
- Timeout:
  - cycle_cnt increments every enabled cycle in RUN.
  - When TIMEOUT!=0 and cycle_cnt reaches TIMEOUT-1 with no pass on that edge: FAIL, code 3.
  - Pass on the same edge as the timeout wins (code stays 0).
- cycle_cnt freezes once done is set.
- mem_write==0: only the counter and timeout logic act.
- en==0: full hold, including the counter. Stores are ignored and never evaluated later.
- pass and fail_code!=0 are mutually exclusive; done == pass | (fail_code!=0).
- Equality is exact bitwise compare at full ADDR_W and DATA_W.

Decomposition:
- Package store_checker_pkg holds:
  - typedef enum logic [1:0] {FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT} fail_code_t;
  - typedef enum {S_RUN, S_PASS, S_FAIL} chk_state_t;
  - default table constants.
- No sub-module needed. Table lookup is an index mux inside the block.

Test Plan:
- Default params; stores (96,0), (96,5), (100,7) at cycles 3, 6, 9 after reset release → match_idx 0 after the scratch store at 96, 1 after (96,0)?? No — see ordering: (96,0) first matches index 0 → match_idx=1; (96,5) ignored; (100,7) → pass=1, done=1, fail_code=0 one edge later.
- Stores (96,0) then (100,8) → fail_code=1, fail_addr=100, fail_data=8, pass=0, match_idx stays 1.
- Store (104,7) first → fail_code=2, fail_addr=104. A later (100,7) changes nothing (sticky).
- TIMEOUT=20, no stores → fail_code=3 on the 20th enabled edge, cycle_cnt=19 frozen, fail_addr=0. Repeat with en low for 10 cycles mid-run → fail on the 30th edge.
- TIMEOUT=20, final (100,7) sampled on the 20th enabled edge → pass=1, fail_code=0.
- After pass, assert reset low for 1 edge → all outputs 0. Then replay the first scenario → pass again. Also pulse reset low concurrently with a matching store → the store is ignored and match_idx=0.

Source files
------------

// File: rtl/store_checker_pkg.sv
// Shared types and default expected-store table for the data-memory store checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_checker_pkg;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DATA    = 2'd1,
    FC_ADDR    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_t;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } chk_state_t;

  // Default table: the reference program stores 0 to 96, then 7 to 100.
  localparam int                DEF_N_EXP       = 2;
  localparam int                DEF_ADDR_W      = 32;
  localparam int                DEF_DATA_W      = 32;
  localparam logic [0:1][31:0]  DEF_EXP_ADDR    = {32'd96, 32'd100};
  localparam logic [0:1][31:0]  DEF_EXP_DATA    = {32'd0, 32'd7};
  localparam logic [31:0]       DEF_IGNORE_ADDR = 32'd96;
  localparam logic [31:0]       DEF_TIMEOUT     = 32'd1000;

endpackage

// File: rtl/store_checker_if.sv
// Data-memory write port as seen by the core (master) and by observers (slave).
// Latency: n/a (wiring only).
// Backpressure: none; a store strobe is a single-cycle event that cannot be stalled.
interface store_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/store_checker.sv
// Checks core stores against an ordered expected table; sticky pass/fail with diagnostics.
// Latency: 1 cycle from a sampled store (en=1, RUN) to the registered result.
// Backpressure: none; purely observes the write port, never stalls the core.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int                             N_EXP       = DEF_N_EXP,
  parameter int                             ADDR_W      = DEF_ADDR_W,
  parameter int                             DATA_W      = DEF_DATA_W,
  parameter logic [0:N_EXP-1][ADDR_W-1:0]   EXP_ADDR    = DEF_EXP_ADDR,
  parameter logic [0:N_EXP-1][DATA_W-1:0]   EXP_DATA    = DEF_EXP_DATA,
  parameter bit                             IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0]              IGNORE_ADDR = DEF_IGNORE_ADDR,
  parameter logic [31:0]                    TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  store_checker_if.slave               bus,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [$clog2(N_EXP+1)-1:0]   match_idx,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data,
  output logic [31:0]                  cycle_cnt
);

  localparam int IDX_W = $clog2(N_EXP+1);

  chk_state_t         state_q, state_d;
  fail_code_t         fc_q, fc_d;
  logic               pass_q, pass_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  fa_q, fa_d;
  logic [DATA_W-1:0]  fd_q, fd_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0]  exp_addr;
  logic [DATA_W-1:0]  exp_data;
  logic               addr_hit;
  logic               data_hit;
  logic               scratch_hit;

  // Select the table entry for the next expected store (index mux over N_EXP entries).
  always_comb begin
    exp_addr = '0;
    exp_data = '0;
    for (int i = 0; i < N_EXP; i++) begin
      if (idx_q == IDX_W'(i)) begin
        exp_addr = EXP_ADDR[i];
        exp_data = EXP_DATA[i];
      end
    end
  end

  assign addr_hit    = (bus.data_adr == exp_addr);
  assign data_hit    = (bus.write_data == exp_data);
  assign scratch_hit = IGNORE_EN && (bus.data_adr == IGNORE_ADDR);

  // Next-state: evaluate the sampled store, then the timeout; the counter freezes on the finishing edge.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    cnt_d   = cnt_q;

    if (en && state_q == S_RUN) begin
      if (bus.mem_write) begin
        if (addr_hit && data_hit) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_EXP-1)) begin
            pass_d  = 1'b1;
            state_d = S_PASS;
          end
        end else if (addr_hit) begin
          fc_d    = FC_DATA;
          fa_d    = bus.data_adr;
          fd_d    = bus.write_data;
          state_d = S_FAIL;
        end else if (!scratch_hit) begin
          fc_d    = FC_ADDR;
          fa_d    = bus.data_adr;
          fd_d    = bus.write_data;
          state_d = S_FAIL;
        end
      end

      // A pass or store failure on this same edge takes precedence over the timeout.
      if (state_d == S_RUN && TIMEOUT != 32'd0 && cnt_q == TIMEOUT - 32'd1) begin
        fc_d    = FC_TIMEOUT;
        fa_d    = '0;
        fd_d    = '0;
        state_d = S_FAIL;
      end

      if (state_d == S_RUN && cnt_q != '1) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // State register with synchronous active-low clear that overrides any concurrent store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
      fc_q    <= FC_NONE;
      pass_q  <= 1'b0;
      idx_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign done      = pass_q | (fc_q != FC_NONE);
  assign match_idx = idx_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker with a per-cycle reference model and literal spot checks.
// Latency: outputs compared on the falling edge after each sampling edge.
// Backpressure: n/a.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [1:0]  match_idx;
  logic [31:0] fail_addr, fail_data, cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  store_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_checker #(.TIMEOUT(32'd20)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bus       (bus),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .match_idx (match_idx),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: expected table as plain arrays, rules applied per sampled edge.
  int unsigned exp_a [2] = '{96, 100};
  int unsigned exp_d [2] = '{0, 7};
  int unsigned m_idx = 0, m_fc = 0, m_fa = 0, m_fd = 0, m_cnt = 0;
  bit          m_pass = 0;

  always @(posedge clk) begin
    bit finished;
    finished = 0;
    if (!reset) begin
      m_idx = 0; m_fc = 0; m_fa = 0; m_fd = 0; m_cnt = 0; m_pass = 0;
    end else if (en && !(m_pass || m_fc != 0)) begin
      if (bus.mem_write) begin
        if (bus.data_adr == exp_a[m_idx] && bus.write_data == exp_d[m_idx]) begin
          m_idx = m_idx + 1;
          if (m_idx == 2) begin m_pass = 1; finished = 1; end
        end else if (bus.data_adr == exp_a[m_idx]) begin
          m_fc = 1; m_fa = bus.data_adr; m_fd = bus.write_data; finished = 1;
        end else if (bus.data_adr != 96) begin
          m_fc = 2; m_fa = bus.data_adr; m_fd = bus.write_data; finished = 1;
        end
      end
      if (!finished && m_cnt == 19) begin
        m_fc = 3; m_fa = 0; m_fd = 0; finished = 1;
      end
      if (!finished) m_cnt = m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset, all outputs must agree with the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("m_done",  {31'd0, done},      {31'd0, (m_pass || m_fc != 0)});
      check("m_pass",  {31'd0, pass},      {31'd0, m_pass});
      check("m_fc",    {30'd0, fail_code}, m_fc);
      check("m_idx",   {30'd0, match_idx}, m_idx);
      check("m_faddr", fail_addr,          m_fa);
      check("m_fdata", fail_data,          m_fd);
      check("m_cnt",   cycle_cnt,          m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write  = 1'b1;
    bus.data_adr   = a;
    bus.write_data = d;
    @(negedge clk);
    bus.mem_write  = 1'b0;
  endtask

  task automatic do_reset();
    bus.mem_write = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fc",   {30'd0, fail_code}, 32'd0);
    check("rst_idx",  {30'd0, match_idx}, 32'd0);
    check("rst_cnt",  cycle_cnt, 32'd0);
  endtask

  task automatic scenario_pass();
    tick(2);
    store(32'd96, 32'd0);
    check("s1_idx1", {30'd0, match_idx}, 32'd1);
    tick(2);
    store(32'd96, 32'd5);
    check("s1_scratch_idx", {30'd0, match_idx}, 32'd1);
    check("s1_scratch_done", {31'd0, done}, 32'd0);
    tick(2);
    store(32'd100, 32'd7);
    check("s1_pass", {31'd0, pass}, 32'd1);
    check("s1_done", {31'd0, done}, 32'd1);
    check("s1_fc",   {30'd0, fail_code}, 32'd0);
    check("s1_idx2", {30'd0, match_idx}, 32'd2);
  endtask

  initial begin
    bus.mem_write  = 1'b0;
    bus.data_adr   = '0;
    bus.write_data = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    cmp_on = 1'b1;

    // In-order pass with an ignored scratch store in between.
    do_reset();
    scenario_pass();
    tick(3);
    check("s1_sticky", {31'd0, pass}, 32'd1);

    // Data mismatch on the second entry.
    do_reset();
    tick(1);
    store(32'd96, 32'd0);
    store(32'd100, 32'd8);
    check("s2_fc",    {30'd0, fail_code}, 32'd1);
    check("s2_faddr", fail_addr, 32'd100);
    check("s2_fdata", fail_data, 32'd8);
    check("s2_pass",  {31'd0, pass}, 32'd0);
    check("s2_idx",   {30'd0, match_idx}, 32'd1);

    // Unexpected address first, then a would-be match is ignored.
    do_reset();
    store(32'd104, 32'd7);
    check("s3_fc",    {30'd0, fail_code}, 32'd2);
    check("s3_faddr", fail_addr, 32'd104);
    check("s3_fdata", fail_data, 32'd7);
    tick(1);
    store(32'd100, 32'd7);
    check("s3_sticky_fc",  {30'd0, fail_code}, 32'd2);
    check("s3_sticky_idx", {30'd0, match_idx}, 32'd0);

    // Timeout with no stores: fail on the 20th enabled edge, counter frozen at 19.
    do_reset();
    tick(19);
    check("s4_pre_fc",  {30'd0, fail_code}, 32'd0);
    check("s4_pre_cnt", cycle_cnt, 32'd19);
    tick(1);
    check("s4_fc",    {30'd0, fail_code}, 32'd3);
    check("s4_cnt",   cycle_cnt, 32'd19);
    check("s4_faddr", fail_addr, 32'd0);
    tick(3);
    check("s4_frozen", cycle_cnt, 32'd19);

    // Timeout with en low for 10 cycles: fail on the 30th edge.
    do_reset();
    tick(5);
    en = 1'b0;
    store(32'd96, 32'd0);
    tick(9);
    check("s4b_hold_cnt", cycle_cnt, 32'd5);
    check("s4b_hold_idx", {30'd0, match_idx}, 32'd0);
    en = 1'b1;
    tick(14);
    check("s4b_pre_fc", {30'd0, fail_code}, 32'd0);
    tick(1);
    check("s4b_fc", {30'd0, fail_code}, 32'd3);

    // Pass sampled on the timeout edge wins.
    do_reset();
    tick(5);
    store(32'd96, 32'd0);
    tick(13);
    check("s5_pre_fc", {30'd0, fail_code}, 32'd0);
    store(32'd100, 32'd7);
    check("s5_pass", {31'd0, pass}, 32'd1);
    check("s5_fc",   {30'd0, fail_code}, 32'd0);

    // Reset after pass clears everything; replay passes again.
    do_reset();
    scenario_pass();

    // Reset concurrent with a matching store: store is discarded.
    do_reset();
    store(32'd96, 32'd0);
    check("s6_idx1", {30'd0, match_idx}, 32'd1);
    bus.mem_write  = 1'b1;
    bus.data_adr   = 32'd100;
    bus.write_data = 32'd7;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.mem_write = 1'b0;
    check("s6_rst_idx",  {30'd0, match_idx}, 32'd0);
    check("s6_rst_pass", {31'd0, pass}, 32'd0);
    tick(2);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
